// File: rtl/attitude_pkg.sv
// attitude_pkg
//   Shared types and constants for the attitude indicator display path.
//   - state_t        : frame writer sequencer states
//   - DEF_*_COLOR    : default colour codes for sky / ground / horizon
//   - Q_FRAC         : fraction bits of the Q4.4 slope
//   - ACC_W          : width of the signed line accumulator (8-bit input + Q_FRAC)
package attitude_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SCAN,
        DONE
    } state_t;

    localparam logic [3:0] DEF_SKY_COLOR     = 4'h1;
    localparam logic [3:0] DEF_GROUND_COLOR  = 4'h2;
    localparam logic [3:0] DEF_HORIZON_COLOR = 4'hF;

    localparam int Q_FRAC = 4;
    localparam int ACC_W  = 12;

endpackage

// File: rtl/horizon_pixel_class.sv
// horizon_pixel_class
//   Combinational sky / horizon / ground classification of one pixel.
//   The horizon row is floor(acc / 2^Q_FRAC); the comparison with the pixel
//   row is signed, so an out-of-range horizon yields an all-sky or
//   all-ground column without any clamping.
// Ports:
//   y_i     : pixel row (unsigned)
//   acc_i   : signed line value at this column, Q_FRAC fraction bits
//   color_o : colour code for the pixel
module horizon_pixel_class
    import attitude_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 4,
    parameter int                    YW            = 2,
    parameter logic [DATA_WIDTH-1:0] SKY_COLOR     = DATA_WIDTH'(DEF_SKY_COLOR),
    parameter logic [DATA_WIDTH-1:0] GROUND_COLOR  = DATA_WIDTH'(DEF_GROUND_COLOR),
    parameter logic [DATA_WIDTH-1:0] HORIZON_COLOR = DATA_WIDTH'(DEF_HORIZON_COLOR)
) (
    input  logic [YW-1:0]           y_i,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [DATA_WIDTH-1:0]   color_o
);

    logic signed [ACC_W-1:0] row;
    logic signed [ACC_W-1:0] y_s;

    assign row = acc_i >>> Q_FRAC;
    assign y_s = signed'(ACC_W'(y_i));

    always_comb begin
        if (y_s < row) begin
            color_o = SKY_COLOR;
        end else if (y_s == row) begin
            color_o = HORIZON_COLOR;
        end else begin
            color_o = GROUND_COLOR;
        end
    end

endmodule

// File: rtl/horizon_frame_writer.sv
// horizon_frame_writer
//   Write-side producer for the dual-clock frame RAM. Accepts one horizon
//   line (Q4.4 slope, integer row offset at column H_RES/2) per frame and
//   writes every pixel, column-major, one per i_Wr_Clk cycle.
//   Optional macro FRAME_SWAP_EN: double-buffered frame, write address gains
//   a bank MSB (= ~o_Disp_Bank) and o_Disp_Bank flips on frame completion.
// Ports:
//   i_Wr_Clk, i_RST        : clock, asynchronous active-high reset
//   i_Valid / o_Ready      : line parameter handshake
//   i_Slope, i_Offset      : signed Q4.4 slope, signed row offset
//   o_Wr_Addr/En/Data      : RAM write port, address {y,x} (+bank MSB)
//   o_Done                 : one-cycle pulse after the last write
//   o_Disp_Bank            : bank the reader must display
module horizon_frame_writer
    import attitude_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 4,
    parameter int                    H_RES         = 8,
    parameter int                    V_RES         = 4,
    parameter logic [DATA_WIDTH-1:0] SKY_COLOR     = DATA_WIDTH'(DEF_SKY_COLOR),
    parameter logic [DATA_WIDTH-1:0] GROUND_COLOR  = DATA_WIDTH'(DEF_GROUND_COLOR),
    parameter logic [DATA_WIDTH-1:0] HORIZON_COLOR = DATA_WIDTH'(DEF_HORIZON_COLOR),
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES),
`ifdef FRAME_SWAP_EN
    localparam int AW = XW + YW + 1
`else
    localparam int AW = XW + YW
`endif
) (
    input  logic                  i_Wr_Clk,
    input  logic                  i_RST,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [7:0]            i_Slope,
    input  logic [7:0]            i_Offset,
    output logic [AW-1:0]         o_Wr_Addr,
    output logic                  o_Wr_En,
    output logic [DATA_WIDTH-1:0] o_Wr_Data,
    output logic                  o_Done,
    output logic                  o_Disp_Bank
);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              slope_q, slope_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic                    wr_en_q, wr_en_d;
    logic [XW+YW-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;

    logic signed [ACC_W-1:0] slope_ext;
    logic [DATA_WIDTH-1:0]   pix_color;

    assign slope_ext = ACC_W'(signed'(slope_q));

    horizon_pixel_class #(
        .DATA_WIDTH    (DATA_WIDTH),
        .YW            (YW),
        .SKY_COLOR     (SKY_COLOR),
        .GROUND_COLOR  (GROUND_COLOR),
        .HORIZON_COLOR (HORIZON_COLOR)
    ) u_class (
        .y_i     (y_q),
        .acc_i   (acc_q),
        .color_o (pix_color)
    );

    // Ready is held off during the o_Done cycle so the next accept is at
    // least one full cycle after the completion pulse.
    assign o_Ready = (state_q == IDLE) && !done_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        slope_d = slope_q;
        x_d     = x_q;
        y_d     = y_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_Valid && o_Ready) begin
                    slope_d = i_Slope;
                    acc_d   = ACC_W'(signed'(i_Offset)) <<< Q_FRAC;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = INIT;
                end
            end
            // Walk the line back from the centre column to x=0; x_q doubles
            // as the step counter here.
            INIT: begin
                acc_d = acc_q - slope_ext;
                if (x_q == XW'(H_RES/2 - 1)) begin
                    x_d     = '0;
                    state_d = SCAN;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            SCAN: begin
                wr_en_d = 1'b1;
                addr_d  = {y_q, x_q};
                data_d  = pix_color;
                if (y_q == YW'(V_RES - 1)) begin
                    y_d   = '0;
                    x_d   = x_q + 1'b1;
                    acc_d = acc_q + slope_ext;
                    if (x_q == XW'(H_RES - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Wr_Clk or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            slope_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            slope_q <= slope_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_Wr_En   = wr_en_q;
    assign o_Wr_Data = data_q;
    assign o_Done    = done_q;

`ifdef FRAME_SWAP_EN
    logic bank_q;

    // Flips on the same edge that raises o_Done.
    always_ff @(posedge i_Wr_Clk or posedge i_RST) begin
        if (i_RST) begin
            bank_q <= 1'b0;
        end else if (state_q == DONE) begin
            bank_q <= ~bank_q;
        end
    end

    assign o_Wr_Addr   = {~bank_q, addr_q};
    assign o_Disp_Bank = bank_q;
`else
    assign o_Wr_Addr   = addr_q;
    assign o_Disp_Bank = 1'b0;
`endif

endmodule

// File: tb/tb_horizon_frame_writer.sv
module tb_horizon_frame_writer;

`ifdef FRAME_SWAP_EN
    localparam int AW = 6;
`else
    localparam int AW = 5;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [7:0]    slope = 8'h00;
    logic [7:0]    offset = 8'h00;
    logic          ready, wr_en, done, bank;
    logic [AW-1:0] addr;
    logic [3:0]    data;

    horizon_frame_writer #(
        .DATA_WIDTH    (4),
        .H_RES         (8),
        .V_RES         (4),
        .SKY_COLOR     (4'h1),
        .GROUND_COLOR  (4'h2),
        .HORIZON_COLOR (4'hF)
    ) dut (
        .i_Wr_Clk    (clk),
        .i_RST       (rst),
        .i_Valid     (valid),
        .o_Ready     (ready),
        .i_Slope     (slope),
        .i_Offset    (offset),
        .o_Wr_Addr   (addr),
        .o_Wr_En     (wr_en),
        .o_Wr_Data   (data),
        .o_Done      (done),
        .o_Disp_Bank (bank)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0]    mem [0:63];
    int            wr_cnt = 0, wr_runs = 0, done_cnt = 0, hi_cnt = 0, bank_bad = 0;
    int            first_wr_cyc = -1, acc_cyc = 0, cyc = 0;
    logic          prev_wr = 1'b0, done_after_last = 1'b0, ready_at_done = 1'b0;
    logic          bank_at_done = 1'b0, exp_wr_bank = 1'b0, timed_out = 1'b0;
    logic          model_bank = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) cyc++;

    // Write-port capture, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mem[int'(addr)] = data;
            wr_cnt++;
            if (!prev_wr) begin
                wr_runs++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
`ifdef FRAME_SWAP_EN
            if (addr[AW-1]) hi_cnt++;
`endif
            if (bank !== exp_wr_bank) bank_bad++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_after_last = prev_wr && (prev_addr[4:0] == 5'd31);
            ready_at_done   = ready;
            bank_at_done    = bank;
        end
        prev_wr   = (wr_en === 1'b1);
        prev_addr = addr;
    end

    function automatic logic [15:0] col(input int base, input int x);
        return {mem[base + 24 + x], mem[base + 16 + x], mem[base + 8 + x], mem[base + x]};
    endfunction

    function automatic int frame_base();
`ifdef FRAME_SWAP_EN
        return model_bank ? 0 : 32;
`else
        return 0;
`endif
    endfunction

    task automatic clear_capture();
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
        wr_cnt = 0; wr_runs = 0; done_cnt = 0; hi_cnt = 0; bank_bad = 0;
        first_wr_cyc = -1; done_after_last = 1'b0; ready_at_done = 1'b1;
        timed_out = 1'b0;
        exp_wr_bank = model_bank;
    endtask

    task automatic start_frame(input logic [7:0] s, input logic [7:0] o);
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            timed_out = 1'b1;
            return;
        end
        slope  = s;
        offset = o;
        valid  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        valid   = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt == 0) timed_out = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", addr); end
        checks++; if (data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h want=0", data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL reset_bank got=%b want=0", bank); end
        rst = 1'b0;
        model_bank = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b want=1", ready); end
    endtask

    task automatic test_flat();
        int base;
        base = frame_base();
        clear_capture();
        start_frame(8'h00, 8'd2);
        wait_done();
        checks++; if (timed_out) begin errors++; $display("FAIL flat_timeout got=timeout want=done"); end
        checks++; if (wr_cnt != 32) begin errors++; $display("FAIL flat_writes got=%0d want=32", wr_cnt); end
        checks++; if (wr_runs != 1) begin errors++; $display("FAIL flat_contiguous got=%0d runs want=1", wr_runs); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL flat_done_count got=%0d want=1", done_cnt); end
        checks++; if (done_after_last !== 1'b1) begin errors++; $display("FAIL flat_done_after_addr31 got=%b want=1", done_after_last); end
        checks++; if (ready_at_done !== 1'b0) begin errors++; $display("FAIL flat_ready_during_done got=%b want=0", ready_at_done); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flat_ready_after_done got=%b want=1", ready); end
        checks++; if (first_wr_cyc - acc_cyc != 5) begin errors++; $display("FAIL flat_latency got=%0d want=5", first_wr_cyc - acc_cyc); end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (col(base, x) !== 16'h2F11) begin errors++; $display("FAIL flat_col%0d got=%h want=2f11", x, col(base, x)); end
        end
`ifdef FRAME_SWAP_EN
        model_bank = ~model_bank;
`endif
    endtask

    task automatic test_slope();
        int base;
        logic [127:0] exp_cols;
        exp_cols = {16'hF111, 16'h2F11, 16'h22F1, 16'h222F, 16'h2222, 16'h2222, 16'h2222, 16'h2222};
        base = frame_base();
        clear_capture();
        start_frame(8'h10, 8'd0);
        wait_done();
        checks++; if (timed_out || wr_cnt != 32) begin errors++; $display("FAIL slope_writes got=%0d timeout=%b want=32", wr_cnt, timed_out); end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (col(base, x) !== exp_cols[x*16 +: 16]) begin
                errors++; $display("FAIL slope_col%0d got=%h want=%h", x, col(base, x), exp_cols[x*16 +: 16]);
            end
        end
`ifdef FRAME_SWAP_EN
        model_bank = ~model_bank;
`endif
    endtask

    task automatic test_offsets();
        int base;
        base = frame_base();
        clear_capture();
        start_frame(8'h00, 8'hF6);
        wait_done();
        checks++; if (timed_out || wr_cnt != 32) begin errors++; $display("FAIL neg_offset_writes got=%0d want=32", wr_cnt); end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (col(base, x) !== 16'h2222) begin errors++; $display("FAIL neg_offset_col%0d got=%h want=2222", x, col(base, x)); end
        end
`ifdef FRAME_SWAP_EN
        model_bank = ~model_bank;
`endif
        base = frame_base();
        clear_capture();
        start_frame(8'h00, 8'd20);
        wait_done();
        checks++; if (timed_out || wr_cnt != 32) begin errors++; $display("FAIL pos_offset_writes got=%0d want=32", wr_cnt); end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (col(base, x) !== 16'h1111) begin errors++; $display("FAIL pos_offset_col%0d got=%h want=1111", x, col(base, x)); end
        end
`ifdef FRAME_SWAP_EN
        model_bank = ~model_bank;
`endif
    endtask

    task automatic test_ignore_valid();
        int base;
        int n;
        base = frame_base();
        clear_capture();
        start_frame(8'h00, 8'd2);
        n = 0;
        while (wr_cnt < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        slope = 8'h10; offset = 8'hF6; valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        checks++; if (timed_out || wr_cnt != 32) begin errors++; $display("FAIL ignore_writes got=%0d want=32", wr_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (col(base, x) !== 16'h2F11) begin errors++; $display("FAIL ignore_col%0d got=%h want=2f11", x, col(base, x)); end
        end
`ifdef FRAME_SWAP_EN
        model_bank = ~model_bank;
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        clear_capture();
        start_frame(8'h00, 8'd2);
        n = 0;
        while (wr_cnt < 10 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got=%b want=0", wr_en); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b want=1", ready); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_bank = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt); end
        checks++; if (wr_cnt != 10) begin errors++; $display("FAIL rstmid_abandoned got=%0d want=10", wr_cnt); end
        clear_capture();
        start_frame(8'h00, 8'd20);
        wait_done();
        checks++; if (timed_out || wr_cnt != 32) begin errors++; $display("FAIL rstmid_refill got=%0d want=32", wr_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_refill_done got=%0d want=1", done_cnt); end
        checks++; if (col(frame_base(), 5) !== 16'h1111) begin errors++; $display("FAIL rstmid_refill_col5 got=%h want=1111", col(frame_base(), 5)); end
`ifdef FRAME_SWAP_EN
        model_bank = ~model_bank;
`endif
    endtask

    task automatic test_frame_swap();
`ifdef FRAME_SWAP_EN
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_bank = 1'b0;
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL swap_bank_reset got=%b want=0", bank); end
        clear_capture();
        start_frame(8'h00, 8'd2);
        wait_done();
        checks++; if (hi_cnt != 32) begin errors++; $display("FAIL swap_f1_back_bank got=%0d want=32", hi_cnt); end
        checks++; if (bank_bad != 0) begin errors++; $display("FAIL swap_f1_bank_during got=%0d bad want=0", bank_bad); end
        checks++; if (bank_at_done !== 1'b1) begin errors++; $display("FAIL swap_f1_bank_at_done got=%b want=1", bank_at_done); end
        checks++; if (col(32, 3) !== 16'h2F11) begin errors++; $display("FAIL swap_f1_col3 got=%h want=2f11", col(32, 3)); end
        checks++; if (col(0, 3) !== 16'h0000) begin errors++; $display("FAIL swap_f1_front_untouched got=%h want=0000", col(0, 3)); end
        model_bank = 1'b1;
        clear_capture();
        start_frame(8'h00, 8'd20);
        wait_done();
        checks++; if (wr_cnt != 32 || hi_cnt != 0) begin errors++; $display("FAIL swap_f2_front_bank got=%0d/%0d want=32/0", wr_cnt, hi_cnt); end
        checks++; if (bank_bad != 0) begin errors++; $display("FAIL swap_f2_bank_during got=%0d bad want=0", bank_bad); end
        checks++; if (bank_at_done !== 1'b0) begin errors++; $display("FAIL swap_f2_bank_at_done got=%b want=0", bank_at_done); end
        checks++; if (col(0, 6) !== 16'h1111) begin errors++; $display("FAIL swap_f2_col6 got=%h want=1111", col(0, 6)); end
        model_bank = 1'b0;
`else
        clear_capture();
        start_frame(8'h10, 8'd0);
        wait_done();
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL single_bank got=%b want=0", bank); end
        checks++; if (bank_bad != 0) begin errors++; $display("FAIL single_bank_during got=%0d bad want=0", bank_bad); end
        checks++; if (col(0, 7) !== 16'hF111) begin errors++; $display("FAIL single_col7 got=%h want=f111", col(0, 7)); end
`endif
    endtask

    initial begin
        test_reset();
        test_flat();
        test_slope();
        test_offsets();
        test_ignore_valid();
        test_reset_mid();
        test_frame_swap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
